// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_unit_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC  = 32'h0000_0000;
  localparam logic [XLEN-1:0] DEFAULT_NOP_INSTR = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_INCR           = 32'd4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_FULL  = 3'd4
  } fetch_state_e;

  // Sequential successor address; wraps modulo 2^32.
  function automatic logic [XLEN-1:0] pcSucc(input logic [XLEN-1:0] pc);
    return pc + PC_INCR;
  endfunction

endpackage

// File: rtl/fetch_unit_hold_buffer.sv
// Single-entry {pc, instr} buffer that parks a response arriving while decode is stalled.
module fetch_hold_buffer
  import fetch_unit_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            i_load,
  input  logic            i_clear,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_instr,
  output logic            o_valid,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_instr
);

  logic            r_valid;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_instr;

  // Clear wins over load so a flush can never leave a stale entry behind.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid <= 1'b0;
      r_pc    <= '0;
      r_instr <= '0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_pc    <= i_pc;
      r_instr <= i_instr;
    end
  end

  assign o_valid = r_valid;
  assign o_pc    = r_pc;
  assign o_instr = r_instr;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, keeps at most one imem request in flight and drives IF/ID.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter logic [XLEN-1:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  input  logic            stall_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_valid_i,
  input  logic [XLEN-1:0] imem_instr_i,
  output logic            if_id_valid_o,
  output logic [XLEN-1:0] if_id_pc_o,
  output logic [XLEN-1:0] if_id_pc_4_o,
  output logic [XLEN-1:0] if_id_instr_o
);

  fetch_unit_pkg::fetch_state_e r_state, w_stateNext;

  logic [XLEN-1:0] r_pc, w_pcNext;
  logic            r_ifValid;
  logic [XLEN-1:0] r_ifPc;
  logic [XLEN-1:0] r_ifInstr;

  logic            w_slotFree;
  logic            w_bufLoad;
  logic            w_bufClear;
  logic            w_bufValid;
  logic [XLEN-1:0] w_bufPc;
  logic [XLEN-1:0] w_bufInstr;
  logic            w_newValid;
  logic [XLEN-1:0] w_newPc;
  logic [XLEN-1:0] w_newInstr;

  assign w_slotFree = !(r_ifValid && stall_i);

  fetch_hold_buffer u_holdBuffer (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_bufLoad),
    .i_clear (w_bufClear),
    .i_pc    (r_pc),
    .i_instr (imem_instr_i),
    .o_valid (w_bufValid),
    .o_pc    (w_bufPc),
    .o_instr (w_bufInstr)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_stateNext;
      r_pc    <= w_pcNext;
    end
  end

  // Next state, next PC, and which instruction (if any) is offered to IF/ID this cycle.
  always_comb begin
    w_stateNext = r_state;
    w_pcNext    = r_pc;
    w_bufLoad   = 1'b0;
    w_bufClear  = 1'b0;
    w_newValid  = 1'b0;
    w_newPc     = r_pc;
    w_newInstr  = imem_instr_i;
    case (r_state)
      ST_IDLE: begin
        w_stateNext = ST_ISSUE;
        if (redirect_i) w_pcNext = redirect_pc_i;
      end
      ST_ISSUE: begin
        if (redirect_i) w_pcNext = redirect_pc_i;
        else            w_stateNext = ST_WAIT;
      end
      ST_WAIT: begin
        if (redirect_i) begin
          w_pcNext    = redirect_pc_i;
          w_stateNext = imem_valid_i ? ST_ISSUE : ST_DRAIN;
        end else if (imem_valid_i) begin
          w_pcNext = pcSucc(r_pc);
          if (w_slotFree) begin
            w_newValid  = 1'b1;
            w_stateNext = ST_ISSUE;
          end else begin
            w_bufLoad   = 1'b1;
            w_stateNext = ST_FULL;
          end
        end
      end
      ST_DRAIN: begin
        if (redirect_i)   w_pcNext    = redirect_pc_i;
        if (imem_valid_i) w_stateNext = ST_ISSUE;
      end
      ST_FULL: begin
        if (redirect_i) begin
          w_bufClear  = 1'b1;
          w_pcNext    = redirect_pc_i;
          w_stateNext = ST_ISSUE;
        end else if (w_slotFree && w_bufValid) begin
          w_bufClear  = 1'b1;
          w_newValid  = 1'b1;
          w_newPc     = w_bufPc;
          w_newInstr  = w_bufInstr;
          w_stateNext = ST_ISSUE;
        end
      end
      default: w_stateNext = ST_IDLE;
    endcase
  end

  // Redirect flushes even under stall; a stalled slot holds; an empty cycle leaves a bubble.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ifValid <= 1'b0;
      r_ifPc    <= '0;
      r_ifInstr <= NOP_INSTR;
    end else if (redirect_i) begin
      r_ifValid <= 1'b0;
      r_ifInstr <= NOP_INSTR;
    end else if (w_slotFree) begin
      if (w_newValid) begin
        r_ifValid <= 1'b1;
        r_ifPc    <= w_newPc;
        r_ifInstr <= w_newInstr;
      end else begin
        r_ifValid <= 1'b0;
        r_ifInstr <= NOP_INSTR;
      end
    end
  end

  assign imem_req_o    = (r_state == ST_ISSUE);
  assign imem_addr_o   = r_pc;
  assign if_id_valid_o = r_ifValid;
  assign if_id_pc_o    = r_ifPc;
  assign if_id_pc_4_o  = pcSucc(r_ifPc);
  assign if_id_instr_o = r_ifInstr;

endmodule
